load_store_unit: RTL and testbench

Load/store unit between the execute stage and the byte-addressed data memory. Accepts one memory request at a time over a valid/ready handshake, checks alignment and range, drives the data memory's address/write-data/write-code/cut-select inputs, and sign- or zero-extends load data. Returns one response per request over a second valid/ready handshake. Optionally supports an LL/SC link register for atomic read-modify-write.

---
 rtl/lsu_pkg.sv | 56 +++++
 rtl/lsu_if.sv | 24 ++
 rtl/lsu_load_ext.sv | 21 ++
 rtl/load_store_unit.sv | 174 +++++++++++++++++
 tb/tb_load_store_unit.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: opcodes, memory codes, FSM states
// and per-opcode decode helpers.
package lsu_pkg;

   localparam logic [3:0] OP_LW  = 4'd0;
   localparam logic [3:0] OP_LB  = 4'd1;
   localparam logic [3:0] OP_LBU = 4'd2;
   localparam logic [3:0] OP_LH  = 4'd3;
   localparam logic [3:0] OP_LHU = 4'd4;
   localparam logic [3:0] OP_SW  = 4'd5;
   localparam logic [3:0] OP_SB  = 4'd6;
   localparam logic [3:0] OP_SH  = 4'd7;
   localparam logic [3:0] OP_LL  = 4'd8;
   localparam logic [3:0] OP_SC  = 4'd9;

   localparam logic [2:0] WR_RD   = 3'd0;
   localparam logic [2:0] WR_WORD = 3'd1;
   localparam logic [2:0] WR_BYTE = 3'd2;
   localparam logic [2:0] WR_SC   = 3'd3;
   localparam logic [2:0] WR_HALF = 3'd4;

   localparam logic [1:0] CUT_WORD = 2'd0;
   localparam logic [1:0] CUT_BYTE = 2'd1;
   localparam logic [1:0] CUT_HALF = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_READ,
      ST_RESP
   } lsu_state_t;

   // Access size in bytes; 0 marks an illegal opcode.
   function automatic logic [2:0] op_size(input logic [3:0] op);
      case (op)
         OP_LW, OP_SW, OP_LL, OP_SC: op_size = 3'd4;
         OP_LH, OP_LHU, OP_SH:       op_size = 3'd2;
         OP_LB, OP_LBU, OP_SB:       op_size = 3'd1;
         default:                    op_size = 3'd0;
      endcase
   endfunction

   function automatic logic op_is_load(input logic [3:0] op);
      op_is_load = (op == OP_LW) || (op == OP_LB) || (op == OP_LBU) ||
                   (op == OP_LH) || (op == OP_LHU) || (op == OP_LL);
   endfunction

   function automatic logic [1:0] op_cut(input logic [3:0] op);
      case (op)
         OP_LB, OP_LBU: op_cut = CUT_BYTE;
         OP_LH, OP_LHU: op_cut = CUT_HALF;
         default:       op_cut = CUT_WORD;
      endcase
   endfunction

endpackage

// File: rtl/lsu_if.sv
// Execute-stage request/response handshake bundle for the load/store unit.
interface lsu_if;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [4:0]  req_rd;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_data;
   logic [4:0]  resp_rd;
   logic        resp_err;

   modport master (
      output req_valid, req_op, req_addr, req_wdata, req_rd, resp_ready,
      input  req_ready, resp_valid, resp_data, resp_rd, resp_err
   );

   modport slave (
      input  req_valid, req_op, req_addr, req_wdata, req_rd, resp_ready,
      output req_ready, resp_valid, resp_data, resp_rd, resp_err
   );
endinterface

// File: rtl/lsu_load_ext.sv
// Sign/zero extension of memory read data according to the load opcode.
module lsu_load_ext
   import lsu_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [31:0] rdata,
   output logic [31:0] data
);

   always_comb begin
      data = rdata;
      case (op)
         OP_LB:   data = {{24{rdata[7]}}, rdata[7:0]};
         OP_LBU:  data = {24'd0, rdata[7:0]};
         OP_LH:   data = {{16{rdata[15]}}, rdata[15:0]};
         OP_LHU:  data = {16'd0, rdata[15:0]};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, alignment/range checks, memory drive,
// load extension. Optional LL/SC link register enabled by LSU_LLSC_EN.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned DEPTH = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   lsu_if.slave        bus,
   output logic [31:0] mem_ad,
   output logic [31:0] mem_wrdata,
   output logic [2:0]  mem_wr,
   output logic [1:0]  mem_cut,
   input  logic [31:0] mem_rdata
);

   lsu_state_t  state_reg;
   logic [3:0]  op_reg;
   logic        req_ready_reg;
   logic        resp_valid_reg;
   logic [31:0] resp_data_reg;
   logic [4:0]  resp_rd_reg;
   logic        resp_err_reg;
   logic [31:0] mem_ad_reg;
   logic [31:0] mem_wrdata_reg;
   logic [2:0]  mem_wr_reg;
   logic [1:0]  mem_cut_reg;

   logic [2:0]  req_size;
   logic [32:0] req_end;
   logic        req_misaligned;
   logic        req_bad;
   logic        req_load;
   logic        req_store;
   logic        sc_fail;
   logic [31:0] ext_data;

   function automatic logic [2:0] store_code(input logic [3:0] op);
      case (op)
         OP_SB:   store_code = WR_BYTE;
         OP_SH:   store_code = WR_HALF;
`ifdef LSU_LLSC_EN
         OP_SC:   store_code = WR_SC;
`endif
         default: store_code = WR_WORD;
      endcase
   endfunction

   assign req_size       = op_size(bus.req_op);
   // 33-bit sum so addresses near 2^32 cannot wrap back into range
   assign req_end        = {1'b0, bus.req_addr} + {30'd0, req_size};
   assign req_misaligned = ((req_size == 3'd4) && (bus.req_addr[1:0] != 2'd0)) ||
                           ((req_size == 3'd2) && bus.req_addr[0]);
   assign req_bad        = (req_size == 3'd0) || req_misaligned || (req_end > 33'(DEPTH));
   assign req_load       = op_is_load(bus.req_op);
   assign req_store      = (bus.req_op == OP_SW) || (bus.req_op == OP_SB) ||
                           (bus.req_op == OP_SH) || (bus.req_op == OP_SC);

`ifdef LSU_LLSC_EN
   logic        link_valid_reg;
   logic [29:0] link_addr_reg;
   logic        link_hit;

   assign link_hit = link_valid_reg && (link_addr_reg == bus.req_addr[31:2]);
   assign sc_fail  = (bus.req_op == OP_SC) && !link_hit;
`else
   assign sc_fail  = 1'b0;
`endif

   lsu_load_ext u_load_ext (
      .op    (op_reg),
      .rdata (mem_rdata),
      .data  (ext_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= ST_IDLE;
         op_reg         <= OP_LW;
         req_ready_reg  <= 1'b1;
         resp_valid_reg <= 1'b0;
         resp_data_reg  <= 32'd0;
         resp_rd_reg    <= 5'd0;
         resp_err_reg   <= 1'b0;
         mem_ad_reg     <= 32'd0;
         mem_wrdata_reg <= 32'd0;
         mem_wr_reg     <= WR_RD;
         mem_cut_reg    <= CUT_WORD;
`ifdef LSU_LLSC_EN
         link_valid_reg <= 1'b0;
         link_addr_reg  <= 30'd0;
`endif
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (bus.req_valid) begin
                  req_ready_reg <= 1'b0;
                  op_reg        <= bus.req_op;
                  resp_rd_reg   <= bus.req_rd;
                  if (req_bad || sc_fail) begin
                     // Rejected requests and failed SCs never touch memory
                     resp_err_reg   <= req_bad;
                     resp_data_reg  <= 32'd0;
                     resp_valid_reg <= 1'b1;
                     state_reg      <= ST_RESP;
                  end else begin
                     mem_ad_reg     <= bus.req_addr;
                     mem_wrdata_reg <= bus.req_wdata;
                     if (req_load) begin
                        mem_wr_reg  <= WR_RD;
                        mem_cut_reg <= op_cut(bus.req_op);
                     end else begin
                        mem_wr_reg  <= store_code(bus.req_op);
                     end
                     state_reg <= ST_ACCESS;
                  end
`ifdef LSU_LLSC_EN
                  if (bus.req_op == OP_SC) begin
                     link_valid_reg <= 1'b0;
                  end else if (!req_bad && (bus.req_op == OP_LL)) begin
                     link_valid_reg <= 1'b1;
                     link_addr_reg  <= bus.req_addr[31:2];
                  end else if (!req_bad && req_store && link_hit) begin
                     link_valid_reg <= 1'b0;
                  end
`endif
               end
            end
            ST_ACCESS: begin
               mem_wr_reg <= WR_RD;
               if (op_is_load(op_reg)) begin
                  state_reg <= ST_READ;
               end else begin
                  resp_data_reg  <= (op_reg == OP_SC) ? 32'd1 : 32'd0;
                  resp_err_reg   <= 1'b0;
                  resp_valid_reg <= 1'b1;
                  state_reg      <= ST_RESP;
               end
            end
            ST_READ: begin
               resp_data_reg  <= ext_data;
               resp_err_reg   <= 1'b0;
               resp_valid_reg <= 1'b1;
               state_reg      <= ST_RESP;
            end
            ST_RESP: begin
               if (bus.resp_ready) begin
                  resp_valid_reg <= 1'b0;
                  req_ready_reg  <= 1'b1;
                  state_reg      <= ST_IDLE;
               end
            end
            default: begin
               mem_wr_reg     <= WR_RD;
               resp_valid_reg <= 1'b0;
               req_ready_reg  <= 1'b1;
               state_reg      <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready  = req_ready_reg;
   assign bus.resp_valid = resp_valid_reg;
   assign bus.resp_data  = resp_data_reg;
   assign bus.resp_rd    = resp_rd_reg;
   assign bus.resp_err   = resp_err_reg;
   assign mem_ad         = mem_ad_reg;
   assign mem_wrdata     = mem_wrdata_reg;
   assign mem_wr         = mem_wr_reg;
   assign mem_cut        = mem_cut_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a byte-array memory model;
// covers the LL/SC path when LSU_LLSC_EN is defined.
module tb_load_store_unit;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] mem_ad, mem_wrdata, mem_rdata;
   logic [2:0]  mem_wr;
   logic [1:0]  mem_cut;

   always #5 clk = ~clk;

   lsu_if bus ();

   load_store_unit #(.DEPTH(64)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .mem_ad     (mem_ad),
      .mem_wrdata (mem_wrdata),
      .mem_wr     (mem_wr),
      .mem_cut    (mem_cut),
      .mem_rdata  (mem_rdata)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%08h required=%08h", name, act, exp);
      end
   endtask

   // Byte memory, little-endian, read data registered one cycle after the drive
   logic [7:0] mem [0:63];

   function automatic logic [7:0] rd8(input int a);
      return mem[a & 63];
   endfunction

   always @(posedge clk) begin
      automatic int a = int'(mem_ad[5:0]);
      case (mem_wr)
         3'd1, 3'd3: begin
            mem[a & 63]       = mem_wrdata[7:0];
            mem[(a + 1) & 63] = mem_wrdata[15:8];
            mem[(a + 2) & 63] = mem_wrdata[23:16];
            mem[(a + 3) & 63] = mem_wrdata[31:24];
         end
         3'd2: mem[a & 63] = mem_wrdata[7:0];
         3'd4: begin
            mem[a & 63]       = mem_wrdata[7:0];
            mem[(a + 1) & 63] = mem_wrdata[15:8];
         end
         default: ;
      endcase
      case (mem_cut)
         2'd1:    mem_rdata <= {24'd0, rd8(a)};
         2'd2:    mem_rdata <= {16'd0, rd8(a + 1), rd8(a)};
         default: mem_rdata <= {rd8(a + 3), rd8(a + 2), rd8(a + 1), rd8(a)};
      endcase
   end

   int          wr_pulses = 0;
   logic [2:0]  last_wr = 3'd0;
   logic [31:0] last_ad = 32'd0;

   always @(negedge clk) begin
      if (mem_wr != 3'd0) begin
         wr_pulses++;
         last_wr = mem_wr;
         last_ad = mem_ad;
      end
   end

   typedef struct {
      logic [31:0] data;
      logic [4:0]  rd;
      logic        err;
   } exp_t;

   exp_t exp_q[$];

   always @(negedge clk) begin
      if (rst_n && bus.resp_valid && bus.resp_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_resp", {27'd0, bus.resp_rd}, 32'hFFFF_FFFF);
         end else begin
            automatic exp_t e = exp_q.pop_front();
            $display("resp rd=%0d data=%08h err=%0b (expect %08h err=%0b)",
                     bus.resp_rd, bus.resp_data, bus.resp_err, e.data, e.err);
            chk("resp_data", bus.resp_data, e.data);
            chk("resp_rd", {27'd0, bus.resp_rd}, {27'd0, e.rd});
            chk("resp_err", {31'd0, bus.resp_err}, {31'd0, e.err});
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (!bus.req_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("req_ready_timeout", {31'd0, bus.req_ready}, 32'd1);
   endtask

   // exp_lat < 0 skips the latency check (direct-to-RESP paths)
   task automatic do_req(input string name, input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd,
                         input logic [31:0] exp_data, input logic exp_err,
                         input int exp_lat, input int exp_pulses);
      int p0;
      int lat;
      wait_idle();
      exp_q.push_back('{data: exp_data, rd: rd, err: exp_err});
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      bus.req_rd    = rd;
      p0 = wr_pulses;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      lat = 0;
      while (!bus.resp_valid && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({name, "_valid"}, {31'd0, bus.resp_valid}, 32'd1);
      if (exp_lat >= 0) chk({name, "_latency"}, lat, exp_lat);
      chk({name, "_wr_pulses"}, wr_pulses - p0, exp_pulses);
      @(posedge clk); #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 8'h00;
      mem[5]  = 8'h80;
      mem[8]  = 8'h44;
      mem[9]  = 8'h33;
      mem[10] = 8'h22;
      mem[11] = 8'h11;
      bus.req_valid  = 1'b0;
      bus.req_op     = 4'd0;
      bus.req_addr   = 32'd0;
      bus.req_wdata  = 32'd0;
      bus.req_rd     = 5'd0;
      bus.resp_ready = 1'b1;

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
      chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
      chk("rst_resp_data", bus.resp_data, 32'd0);
      chk("rst_resp_rd", {27'd0, bus.resp_rd}, 32'd0);
      chk("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
      chk("rst_mem_wr", {29'd0, mem_wr}, 32'd0);
      chk("rst_mem_ad", mem_ad, 32'd0);
      chk("rst_mem_cut", {30'd0, mem_cut}, 32'd0);

      do_req("lb5",  OP_LB,  32'd5, 32'd0, 5'd1, 32'hFFFF_FF80, 1'b0, 2, 0);
      do_req("lbu5", OP_LBU, 32'd5, 32'd0, 5'd2, 32'h0000_0080, 1'b0, 2, 0);
      do_req("sh6",  OP_SH,  32'd6, 32'h1234_ABCD, 5'd3, 32'd0, 1'b0, 1, 1);
      chk("sh6_wr_code", {29'd0, last_wr}, 32'd4);
      chk("sh6_wr_addr", last_ad, 32'd6);
      do_req("lhu6", OP_LHU, 32'd6, 32'd0, 5'd4, 32'h0000_ABCD, 1'b0, 2, 0);
      do_req("lh6",  OP_LH,  32'd6, 32'd0, 5'd5, 32'hFFFF_ABCD, 1'b0, 2, 0);
      do_req("lw2_misalign", OP_LW, 32'd2,  32'd0, 5'd6, 32'd0, 1'b1, -1, 0);
      do_req("lw64_range",   OP_LW, 32'd64, 32'd0, 5'd7, 32'd0, 1'b1, -1, 0);
      do_req("lw60_edge",    OP_LW, 32'd60, 32'd0, 5'd8, 32'd0, 1'b0, 2, 0);
      do_req("lh63_misalign", OP_LH, 32'd63, 32'd0, 5'd9, 32'd0, 1'b1, -1, 0);
      do_req("lb63_edge",    OP_LB, 32'd63, 32'd0, 5'd10, 32'd0, 1'b0, 2, 0);
      do_req("lb64_range",   OP_LB, 32'd64, 32'd0, 5'd11, 32'd0, 1'b1, -1, 0);
      do_req("illegal_op",   4'd12, 32'd0,  32'd0, 5'd12, 32'd0, 1'b1, -1, 0);
      do_req("sw12", OP_SW, 32'd12, 32'hDEAD_BEEF, 5'd13, 32'd0, 1'b0, 1, 1);
      do_req("lw12", OP_LW, 32'd12, 32'd0, 5'd14, 32'hDEAD_BEEF, 1'b0, 2, 0);
      do_req("sb16", OP_SB, 32'd16, 32'h1234_56A5, 5'd15, 32'd0, 1'b0, 1, 1);
      chk("sb16_wr_code", {29'd0, last_wr}, 32'd2);
      do_req("lb16", OP_LB, 32'd16, 32'd0, 5'd16, 32'hFFFF_FFA5, 1'b0, 2, 0);
      do_req("lw8",  OP_LW, 32'd8,  32'd0, 5'd17, 32'h1122_3344, 1'b0, 2, 0);

      // Backpressure: response must hold while resp_ready is low
      wait_idle();
      bus.resp_ready = 1'b0;
      exp_q.push_back('{data: 32'h1122_3344, rd: 5'd7, err: 1'b0});
      bus.req_valid = 1'b1;
      bus.req_op    = OP_LW;
      bus.req_addr  = 32'd8;
      bus.req_rd    = 5'd7;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      for (int i = 0; i < 10 && !bus.resp_valid; i++) begin
         @(posedge clk); #1;
      end
      for (int i = 0; i < 5; i++) begin
         chk("bp_resp_valid", {31'd0, bus.resp_valid}, 32'd1);
         chk("bp_resp_data", bus.resp_data, 32'h1122_3344);
         chk("bp_resp_rd", {27'd0, bus.resp_rd}, 32'd7);
         chk("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
         @(posedge clk); #1;
      end
      bus.resp_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_released", {31'd0, bus.resp_valid}, 32'd0);

`ifdef LSU_LLSC_EN
      do_req("ll8",  OP_LL, 32'd8, 32'd0, 5'd18, 32'h1122_3344, 1'b0, 2, 0);
      do_req("sc8_ok", OP_SC, 32'd8, 32'd7, 5'd19, 32'd1, 1'b0, 1, 1);
      chk("sc8_wr_code", {29'd0, last_wr}, 32'd3);
      do_req("lw8_after_sc", OP_LW, 32'd8, 32'd0, 5'd20, 32'd7, 1'b0, 2, 0);
      do_req("ll8_b", OP_LL, 32'd8, 32'd0, 5'd21, 32'd7, 1'b0, 2, 0);
      do_req("sb9",   OP_SB, 32'd9, 32'd0, 5'd22, 32'd0, 1'b0, 1, 1);
      do_req("sc8_fail", OP_SC, 32'd8, 32'd9, 5'd23, 32'd0, 1'b0, -1, 0);
      do_req("lw8_after_fail", OP_LW, 32'd8, 32'd0, 5'd24, 32'd7, 1'b0, 2, 0);
`else
      do_req("sc8_plain", OP_SC, 32'd8, 32'd7, 5'd19, 32'd1, 1'b0, 1, 1);
      chk("sc8_wr_code", {29'd0, last_wr}, 32'd1);
      do_req("ll8_plain", OP_LL, 32'd8, 32'd0, 5'd20, 32'd7, 1'b0, 2, 0);
`endif

      // Reset during the ACCESS cycle of a store must abort the write
      wait_idle();
      bus.req_valid = 1'b1;
      bus.req_op    = OP_SW;
      bus.req_addr  = 32'd20;
      bus.req_wdata = 32'h0000_0055;
      bus.req_rd    = 5'd25;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      chk("rstacc_mem_wr_before", {29'd0, mem_wr}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rstacc_mem_wr_async", {29'd0, mem_wr}, 32'd0);
      chk("rstacc_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rstacc_req_ready", {31'd0, bus.req_ready}, 32'd1);
      chk("rstacc_mem20", {24'd0, mem[20]}, 32'd0);
      do_req("lw20_after_rst", OP_LW, 32'd20, 32'd0, 5'd26, 32'd0, 1'b0, 2, 0);

      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_empty", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
